// File: rtl/tlp_pkg.sv
// Shared TLP encodings, stream bit positions and requester FSM states.
// Also used by the HardwareSubunit completer side.
package tlp_pkg;

  localparam logic [2:0] FMT_RD     = 3'b000;
  localparam logic [2:0] FMT_WR     = 3'b010;
  localparam int         FMT_WR_BIT = 6;

  localparam logic [4:0] TYPE_MEM  = 5'b00000;
  localparam logic [4:0] TYPE_IO   = 5'b00010;
  localparam logic [4:0] TYPE_CFG0 = 5'b00100;
  localparam logic [4:0] TYPE_CFG1 = 5'b00101;

  localparam logic [3:0] CPL_SC = 4'b1000;

  localparam int DW_EOP = 34;
  localparam int DW_SOP = 33;
  localparam int DW_VLD = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HDR      = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_WAIT_CPL = 2'd3
  } state_e;

  function automatic logic req_ok(input logic [7:0] tfmt, input logic addr_hi_nz,
                                  input logic [9:0] len);
    logic type_ok;
    type_ok = (tfmt[4:0] == TYPE_MEM) || (tfmt[4:0] == TYPE_IO) ||
              (tfmt[4:0] == TYPE_CFG0) || (tfmt[4:0] == TYPE_CFG1);
    if (!type_ok)
      return 1'b0;
    if (tfmt[4:0] == TYPE_MEM)
      return (len != 10'd0);
    return !addr_hi_nz;
  endfunction

endpackage

// File: rtl/tlp_hdr_builder.sv
// Combinational header DW builder: DW0..DW3 from request fields and tag.
module tlp_hdr_builder
  import tlp_pkg::*;
#(
  parameter logic [15:0] REQ_ID = 16'h0100
) (
  input  logic [7:0]  tfmt,
  input  logic [63:0] addr,
  input  logic [9:0]  len,
  input  logic [7:0]  tag,
  output logic [31:0] dw0,
  output logic [31:0] dw1,
  output logic [31:0] dw2,
  output logic [31:0] dw3,
  output logic        is_4dw
);

  logic       is_mem;
  logic [2:0] fmt;
  logic [9:0] len_f;
  logic       unused_fmt5;

  // bit5 of the caller's fmt is ignored; header size is decided here
  assign unused_fmt5 = tfmt[5];

  assign is_mem = (tfmt[4:0] == TYPE_MEM);
  assign is_4dw = is_mem && (addr[63:32] != 32'd0);
  assign fmt    = {tfmt[7:6], is_4dw};
  assign len_f  = is_mem ? len : 10'd0;

  assign dw0 = {fmt, tfmt[4:0], 14'd0, len_f};
  assign dw1 = {REQ_ID, tag, 8'hFF};
  assign dw2 = is_4dw ? addr[63:32] : addr[31:0];
  assign dw3 = addr[31:0];

endmodule

// File: rtl/tlp_request_generator.sv
// Requester side of the TLP link: serialises one request onto the 35-bit
// stream, then collects completion words from the completer.
//   state       | meaning
//   ST_IDLE     | ready for a request, stream idle
//   ST_HDR      | sending header DW1..last
//   ST_PAYLOAD  | sending mem-write payload DWs as wr_valid allows
//   ST_WAIT_CPL | cpl_ready up, waiting for completion words / timeout
module tlp_request_generator
  import tlp_pkg::*;
#(
  parameter logic [15:0] REQ_ID  = 16'h0100,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_tfmt,
  input  logic [63:0] req_addr,
  input  logic [9:0]  req_len,
  input  logic [31:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [34:0] tlp_out,
  input  logic [31:0] cpl_data,
  input  logic [3:0]  cpl_status,
  output logic        cpl_ready,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic        error
);

  localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  tag_q, tag_d;
  logic [1:0]  dw_idx_q, dw_idx_d;
  logic [9:0]  pay_cnt_q, pay_cnt_d;
  logic [15:0] tmo_q, tmo_d;
  logic [7:0]  tfmt_q, tfmt_d;
  logic [63:0] addr_q, addr_d;
  logic [9:0]  len_q, len_d;
  logic [7:0]  rtag_q, rtag_d;
  logic [34:0] tlp_out_q, tlp_out_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        req_ready_q, req_ready_d;
  logic        cpl_ready_q, cpl_ready_d;

  logic        in_idle, is_mem, has_pay, is_mrd, last_hdr, cpl_word, capture;
  logic [7:0]  hb_tfmt, hb_tag;
  logic [63:0] hb_addr;
  logic [9:0]  hb_len;
  logic [31:0] hb_dw0, hb_dw1, hb_dw2, hb_dw3, hdr_dw;
  logic        hb_is_4dw;

  // In IDLE the builder sees the live request so DW0 goes out the cycle after accept
  assign in_idle = (state_q == ST_IDLE);
  assign hb_tfmt = in_idle ? req_tfmt : tfmt_q;
  assign hb_addr = in_idle ? req_addr : addr_q;
  assign hb_len  = in_idle ? req_len  : len_q;
  assign hb_tag  = in_idle ? tag_q    : rtag_q;

  tlp_hdr_builder #(.REQ_ID(REQ_ID)) u_hdr (
    .tfmt   (hb_tfmt),
    .addr   (hb_addr),
    .len    (hb_len),
    .tag    (hb_tag),
    .dw0    (hb_dw0),
    .dw1    (hb_dw1),
    .dw2    (hb_dw2),
    .dw3    (hb_dw3),
    .is_4dw (hb_is_4dw)
  );

  assign is_mem   = (tfmt_q[4:0] == TYPE_MEM);
  assign has_pay  = is_mem && tfmt_q[FMT_WR_BIT];
  assign is_mrd   = is_mem && !tfmt_q[FMT_WR_BIT];
  assign last_hdr = (dw_idx_q == (hb_is_4dw ? 2'd3 : 2'd2));
  assign cpl_word = cpl_ready_q && (cpl_status == CPL_SC);
  assign capture  = (state_q == ST_WAIT_CPL) && is_mrd && cpl_word && (cpl_data != 32'd0);

  always_comb begin
    case (dw_idx_q)
      2'd0:    hdr_dw = hb_dw0;
      2'd1:    hdr_dw = hb_dw1;
      2'd2:    hdr_dw = hb_dw2;
      default: hdr_dw = hb_dw3;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    dw_idx_d   = dw_idx_q;
    pay_cnt_d  = pay_cnt_q;
    tmo_d      = tmo_q;
    tfmt_d     = tfmt_q;
    addr_d     = addr_q;
    len_d      = len_q;
    rtag_d     = rtag_q;
    tlp_out_d  = {3'b000, tlp_out_q[31:0]};
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    error_d    = 1'b0;
    wr_ready   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          tag_d = tag_q + 8'd1;
          if (!req_ok(req_tfmt, req_addr[63:32] != 32'd0, req_len)) begin
            error_d = 1'b1;
          end else begin
            tfmt_d    = req_tfmt;
            addr_d    = req_addr;
            len_d     = req_len;
            rtag_d    = tag_q;
            pay_cnt_d = req_len;
            dw_idx_d  = 2'd1;
            tlp_out_d = {1'b0, 1'b1, 1'b1, hb_dw0};
            state_d   = ST_HDR;
          end
        end
      end
      ST_HDR: begin
        tlp_out_d = {last_hdr && !has_pay, 1'b0, 1'b1, hdr_dw};
        dw_idx_d  = dw_idx_q + 2'd1;
        if (last_hdr) begin
          dw_idx_d = 2'd0;
          if (has_pay) begin
            state_d = ST_PAYLOAD;
          end else begin
            state_d = ST_WAIT_CPL;
            tmo_d   = TMO_LOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        wr_ready = wr_valid;
        if (wr_valid) begin
          tlp_out_d = {pay_cnt_q == 10'd1, 1'b0, 1'b1, wr_data};
          pay_cnt_d = pay_cnt_q - 10'd1;
          if (pay_cnt_q == 10'd1) begin
            state_d = ST_WAIT_CPL;
            tmo_d   = TMO_LOAD;
          end
        end
      end
      default: begin
        tmo_d = tmo_q - 16'd1;
        if (capture) begin
          rd_data_d  = cpl_data;
          rd_valid_d = 1'b1;
          tmo_d      = TMO_LOAD;
          pay_cnt_d  = pay_cnt_q - 10'd1;
          if (pay_cnt_q == 10'd1) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (!is_mrd && cpl_word) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (tmo_q == 16'd1) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
    endcase
    req_ready_d = (state_d == ST_IDLE);
    // one-cycle drop after a capture lets the completer clear its data word
    cpl_ready_d = (state_d == ST_WAIT_CPL) && !capture;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tag_q       <= 8'd0;
      dw_idx_q    <= 2'd0;
      pay_cnt_q   <= 10'd0;
      tmo_q       <= 16'd0;
      tfmt_q      <= 8'd0;
      addr_q      <= 64'd0;
      len_q       <= 10'd0;
      rtag_q      <= 8'd0;
      tlp_out_q   <= 35'd0;
      rd_data_q   <= 32'd0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      req_ready_q <= 1'b0;
      cpl_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      dw_idx_q    <= dw_idx_d;
      pay_cnt_q   <= pay_cnt_d;
      tmo_q       <= tmo_d;
      tfmt_q      <= tfmt_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      rtag_q      <= rtag_d;
      tlp_out_q   <= tlp_out_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      error_q     <= error_d;
      req_ready_q <= req_ready_d;
      cpl_ready_q <= cpl_ready_d;
    end
  end

  assign req_ready = req_ready_q;
  assign cpl_ready = cpl_ready_q;
  assign tlp_out   = tlp_out_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_tlp_request_generator.sv
// Directed bench for tlp_request_generator with hand-computed stream words.
module tb_tlp_request_generator;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_tfmt;
  logic [63:0] req_addr;
  logic [9:0]  req_len;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [34:0] tlp_out;
  logic [31:0] cpl_data;
  logic [3:0]  cpl_status;
  logic        cpl_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        done;
  logic        error;

  int errors = 0;
  int checks = 0;

  tlp_request_generator #(.REQ_ID(16'h0100), .TIMEOUT(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_tfmt   (req_tfmt),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .tlp_out    (tlp_out),
    .cpl_data   (cpl_data),
    .cpl_status (cpl_status),
    .cpl_ready  (cpl_ready),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [7:0] tfmt, input logic [63:0] addr, input logic [9:0] len);
    req_tfmt  = tfmt;
    req_addr  = addr;
    req_len   = len;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    int dw1_cnt;
    int guard;
    reset = 1'b1; req_valid = 1'b0; req_tfmt = 8'h00; req_addr = 64'd0; req_len = 10'd0;
    wr_data = 32'd0; wr_valid = 1'b0; cpl_data = 32'd0; cpl_status = 4'd0;
    tick(); tick(); tick();
    chk("rst_outs", {req_ready, wr_ready, cpl_ready, rd_valid, done, error}, 6'b0);
    chk("rst_tlp", tlp_out, 35'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    reset = 1'b0;
    tick();
    chk("ready_after_rst", req_ready, 1'b1);

    // 3DW memory read, two completion words
    offer(8'h00, 64'h0000_0000_1234_5678, 10'd2);
    chk("mrd_dw0", tlp_out, 35'h3_0000_0002);
    chk("mrd_ready_low", req_ready, 1'b0);
    tick();
    chk("mrd_dw1", tlp_out, 35'h1_0100_00FF);
    tick();
    chk("mrd_dw2", tlp_out, 35'h5_1234_5678);
    chk("mrd_cpl_ready", cpl_ready, 1'b1);
    cpl_status = 4'b1000; cpl_data = 32'hEDCB_A987;
    tick();
    chk("mrd_rd1", {rd_valid, rd_data}, {1'b1, 32'hEDCB_A987});
    chk("mrd_cpl_drop", cpl_ready, 1'b0);
    chk("mrd_idle_tlp", tlp_out, 35'h0_1234_5678);
    chk("mrd_no_done1", done, 1'b0);
    cpl_data = 32'd0;
    tick();
    chk("mrd_cpl_back", {cpl_ready, rd_valid}, 2'b10);
    cpl_data = 32'hEDCB_A987;
    tick();
    chk("mrd_rd2", {rd_valid, rd_data}, {1'b1, 32'hEDCB_A987});
    chk("mrd_done", {done, error, req_ready, cpl_ready}, 4'b1010);
    cpl_data = 32'd0; cpl_status = 4'd0;
    tick();
    chk("mrd_done_pulse", done, 1'b0);

    // 4DW memory write with a wr_valid gap
    offer(8'h40, 64'h0000_0001_0000_0010, 10'd3);
    chk("mwr_dw0", tlp_out, 35'h3_6000_0003);
    tick();
    chk("mwr_dw1", tlp_out, 35'h1_0100_01FF);
    tick();
    chk("mwr_dw2", tlp_out, 35'h1_0000_0001);
    tick();
    chk("mwr_dw3", tlp_out, 35'h1_0000_0010);
    wr_valid = 1'b1; wr_data = 32'hA000_0001;
    #1;
    chk("mwr_wr_ready1", wr_ready, 1'b1);
    tick();
    chk("mwr_pay1", tlp_out, 35'h1_A000_0001);
    wr_valid = 1'b0;
    #1;
    chk("mwr_wr_ready_gap", wr_ready, 1'b0);
    tick();
    chk("mwr_gap", tlp_out, 35'h0_A000_0001);
    wr_valid = 1'b1; wr_data = 32'hA000_0002;
    tick();
    chk("mwr_pay2", tlp_out, 35'h1_A000_0002);
    wr_data = 32'hA000_0003;
    tick();
    chk("mwr_pay3_eop", tlp_out, 35'h5_A000_0003);
    chk("mwr_cpl_ready", cpl_ready, 1'b1);
    wr_valid = 1'b0; cpl_status = 4'b1000;
    tick();
    chk("mwr_done", {done, error, rd_valid}, 3'b100);
    cpl_status = 4'd0;
    tick();

    // config read, 3DW header
    offer(8'h04, 64'h0000_0000_0000_0010, 10'd5);
    chk("cfg_dw0", tlp_out, 35'h3_0400_0000);
    tick();
    chk("cfg_dw1", tlp_out, 35'h1_0100_02FF);
    tick();
    chk("cfg_dw2_eop", tlp_out, 35'h5_0000_0010);
    cpl_status = 4'b1000;
    tick();
    chk("cfg_done", {done, error}, 2'b10);
    cpl_status = 4'd0;
    tick();

    // rejected requests: bad type, mem len 0, IO with high address
    offer(8'h07, 64'h0000_0000_0000_0100, 10'd1);
    chk("bad_type_err", {error, req_ready}, 2'b11);
    chk("bad_type_novld", tlp_out[34:32], 3'b000);
    tick();
    chk("bad_type_pulse", {error, tlp_out[34:32]}, 4'b0000);
    offer(8'h00, 64'h0000_0000_0000_0100, 10'd0);
    chk("len0_err", error, 1'b1);
    chk("len0_novld", tlp_out[34:32], 3'b000);
    tick();
    offer(8'h02, 64'h0000_0001_0000_0000, 10'd1);
    chk("io_hi_err", error, 1'b1);
    chk("io_hi_novld", tlp_out[34:32], 3'b000);
    tick();
    chk("io_hi_still_idle", {error, tlp_out[34:32], req_ready}, 5'b00001);

    // read with no completion: error 10 cycles after WAIT_CPL entry
    offer(8'h00, 64'h0000_0000_0000_0040, 10'd1);
    tick();
    chk("tmo_dw1_tag", tlp_out, 35'h1_0100_06FF);
    tick();
    chk("tmo_dw2", tlp_out, 35'h5_0000_0040);
    for (int k = 1; k <= 9; k++) tick();
    chk("tmo_not_yet", {error, cpl_ready}, 2'b01);
    tick();
    chk("tmo_err", {error, cpl_ready, done, req_ready}, 4'b1001);
    tick();

    // reset during payload
    offer(8'h40, 64'h0000_0000_0000_0100, 10'd2);
    chk("rstp_dw0", tlp_out, 35'h3_4000_0002);
    tick();
    chk("rstp_dw1", tlp_out, 35'h1_0100_07FF);
    tick();
    chk("rstp_dw2", tlp_out, 35'h1_0000_0100);
    wr_valid = 1'b1; wr_data = 32'h5555_0001;
    tick();
    chk("rstp_pay1", tlp_out, 35'h1_5555_0001);
    reset = 1'b1;
    tick();
    chk("rstp_outs", {req_ready, wr_ready, cpl_ready, rd_valid, done, error}, 6'b0);
    chk("rstp_tlp", tlp_out, 35'd0);
    chk("rstp_rd_data", rd_data, 32'd0);
    reset = 1'b0; wr_valid = 1'b0;
    tick();

    // 257 back-to-back config reads: tag 255 then wrap to 0
    req_tfmt = 8'h04; req_addr = 64'h10; req_len = 10'd0;
    cpl_status = 4'b1000; cpl_data = 32'd0; req_valid = 1'b1;
    dw1_cnt = 0;
    guard = 0;
    while (dw1_cnt < 257 && guard < 3000) begin
      tick();
      guard++;
      if (tlp_out[34:32] == 3'b001) begin
        if (dw1_cnt == 255) chk("tag_ff", tlp_out, 35'h1_0100_FFFF);
        if (dw1_cnt == 256) chk("tag_wrap", tlp_out, 35'h1_0100_00FF);
        dw1_cnt++;
      end
    end
    chk("wrap_count", dw1_cnt, 257);
    req_valid = 1'b0; cpl_status = 4'd0;
    tick(); tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
